// File: rtl/pwe_pulse_sched.sv
// pwe_pulse_sched: round-robin scheduler sharing one pulse-width engine among NREQ requesters.
// All outputs are flops decoded from the FSM state, so they trail the state by one cycle.
module pwe_pulse_sched #(
    parameter int NREQ    = 4,
    parameter int WIDTH_W = 4,
    parameter int GAP_W   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [GAP_W-1:0]          gap,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH_W-1:0]   req_width,
    output logic [NREQ-1:0]           grant,
    output logic                      pulse_out,
    output logic [NREQ-1:0]           done,
    output logic                      busy
);

    // state   | meaning
    // S_IDLE  | waiting for enable and a request; arbitration happens here
    // S_PULSE | engine driving the owner's pulse, width counter running down
    // S_DONE  | one-cycle completion strobe to the owner, pointer advances
    // S_GAP   | enforced idle cycles before the next arbitration
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_DONE  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t             r_state;
    logic [WIDTH_W-1:0] r_width_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [NREQ-1:0]    r_grant;
    logic [NREQ-1:0]    r_done;
    logic               r_pulse;
    logic               r_busy;

    logic [IDX_W-1:0]   w_pick;
    logic               w_start;
    logic [WIDTH_W-1:0] w_pick_width;
    logic [NREQ-1:0]    w_owner_oh;
    logic [IDX_W-1:0]   w_ptr_next;

    // First set request bit at or above the pointer, wrapping past NREQ-1 back to 0.
    function automatic logic [IDX_W-1:0] f_pick(input logic [NREQ-1:0] req_v,
                                                input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_v[idx]) begin
                found = 1'b1;
                sel   = IDX_W'(idx);
            end
        end
        return sel;
    endfunction

    assign w_pick       = f_pick(req, r_ptr);
    assign w_start      = enable && (req != '0);
    assign w_pick_width = req_width[int'(w_pick)*WIDTH_W +: WIDTH_W];
    assign w_owner_oh   = NREQ'(1) << r_owner;
    assign w_ptr_next   = (r_owner == IDX_W'(NREQ-1)) ? '0 : r_owner + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_width_cnt <= '0;
            r_gap_cnt   <= '0;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_grant     <= '0;
            r_done      <= '0;
            r_pulse     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_pulse <= (r_state == S_PULSE);
            r_grant <= (r_state == S_PULSE || r_state == S_DONE) ? w_owner_oh : '0;
            r_done  <= (r_state == S_DONE) ? w_owner_oh : '0;
            r_busy  <= (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_owner     <= w_pick;
                        r_width_cnt <= w_pick_width;
                        r_gap_cnt   <= gap;
                        r_state     <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    // Test for zero before decrementing so a maximal code never wraps.
                    if (r_width_cnt == '0) r_state <= S_DONE;
                    else                   r_width_cnt <= r_width_cnt - 1'b1;
                end
                S_DONE: begin
                    r_ptr   <= w_ptr_next;
                    r_state <= (r_gap_cnt != '0) ? S_GAP : S_IDLE;
                end
                S_GAP: begin
                    r_gap_cnt <= r_gap_cnt - 1'b1;
                    if (r_gap_cnt == GAP_W'(1)) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant     = r_grant;
    assign pulse_out = r_pulse;
    assign done      = r_done;
    assign busy      = r_busy;

endmodule

// File: tb/tb_pwe_pulse_sched.sv
// Bench for pwe_pulse_sched: transaction-schedule model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_pwe_pulse_sched;

    localparam int NREQ    = 4;
    localparam int WIDTH_W = 4;
    localparam int GAP_W   = 4;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    enable = 1'b0;
    logic [GAP_W-1:0]        gap = '0;
    logic [NREQ-1:0]         req = '0;
    logic [NREQ*WIDTH_W-1:0] req_width = '0;
    logic [NREQ-1:0]         grant;
    logic                    pulse_out;
    logic [NREQ-1:0]         done;
    logic                    busy;

    int checks   = 0;
    int failures = 0;

    pwe_pulse_sched #(.NREQ(NREQ), .WIDTH_W(WIDTH_W), .GAP_W(GAP_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .gap(gap), .req(req),
        .req_width(req_width), .grant(grant), .pulse_out(pulse_out), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // Schedule model: each accepted request at edge s with width w and gap g produces
    // pulse after edges s+1..s+w+1, done after s+w+2, busy after s+1..s+w+2+g,
    // and the next arbitration happens at edge s+w+g+3.
    longint e           = 0;
    longint t_start     = -1000;
    int     t_w         = 0;
    int     t_g         = 0;
    int     t_own       = 0;
    int     m_ptr       = 0;
    longint next_sample = 0;

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return 0;
    endfunction

    initial forever begin
        @(posedge clk);
        e = e + 1;
        if (reset) begin
            t_start     = -1000;
            m_ptr       = 0;
            next_sample = e + 1;
        end else if (e >= next_sample) begin
            if (enable && req != '0) begin
                t_own       = pick(req, m_ptr);
                t_start     = e;
                t_w         = int'(req_width[t_own*WIDTH_W +: WIDTH_W]);
                t_g         = int'(gap);
                m_ptr       = (t_own + 1) % NREQ;
                next_sample = e + t_w + t_g + 3;
            end else begin
                next_sample = e + 1;
            end
        end
    end

    initial forever begin
        logic             x_pulse, x_done, x_busy;
        logic [NREQ-1:0]  x_grant, x_done_v;
        @(negedge clk);
        x_pulse = 1'b0; x_done = 1'b0; x_busy = 1'b0;
        if (!reset) begin
            x_pulse = (e >= t_start + 1) && (e <= t_start + t_w + 1);
            x_done  = (e == t_start + t_w + 2);
            x_busy  = (e >= t_start + 1) && (e <= t_start + t_w + 2 + t_g);
        end
        x_grant  = (x_pulse || x_done) ? NREQ'(1) << t_own : '0;
        x_done_v = x_done ? NREQ'(1) << t_own : '0;
        check("model_pulse", 32'(pulse_out), 32'(x_pulse));
        check("model_grant", 32'(grant), 32'(x_grant));
        check("model_done", 32'(done), 32'(x_done_v));
        check("model_busy", 32'(busy), 32'(x_busy));
    end

    task automatic set_w(input int i, input int w);
        req_width[i*WIDTH_W +: WIDTH_W] = WIDTH_W'(w);
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_pulse_rise();
        int n = 0;
        @(negedge clk);
        while (!pulse_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("pulse_rise_timeout", 32'(pulse_out), 32'd1);
    endtask

    // Returns pulse length; leaves the caller on the negedge of the first low cycle.
    task automatic measure(input int drop_en_at, output int len);
        wait_pulse_rise();
        len = 0;
        while (pulse_out && len < 100) begin
            len++;
            if (len == drop_en_at) enable = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (done == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(done != '0), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, cnt;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // Single requester, W=3, gap=0, then back-to-back repeat.
        reset_dut();
        set_w(0, 3); gap = 0; enable = 1; req = 4'b0001;
        measure(0, len);
        check("t1_len", 32'(len), 32'd4);
        check("t1_done", 32'(done), 32'b0001);
        check("t1_grant_at_done", 32'(grant), 32'b0001);
        @(negedge clk);
        check("t1_busy_low", 32'(busy), 32'd0);
        @(negedge clk);
        check("t1_backtoback", 32'(pulse_out), 32'd1);
        req = 0;

        // All requesting, W=0: round-robin order 0,1,2,3,0.
        reset_dut();
        for (int i = 0; i < NREQ; i++) set_w(i, 0);
        gap = 0; enable = 1; req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_done();
            check("t2_order", 32'(done), 32'(NREQ'(1) << (i % NREQ)));
        end
        req = 0;

        // Minimum and maximum width.
        reset_dut();
        set_w(2, 0); gap = 0; enable = 1; req = 4'b0100;
        measure(0, len);
        req = 0;
        check("t3_len_min", 32'(len), 32'd1);
        set_w(2, 15);
        repeat (3) @(negedge clk);
        req = 4'b0100;
        measure(0, len);
        req = 0;
        check("t3_len_max", 32'(len), 32'd16);

        // Gap of 2 between done[0] and requester 1's pulse.
        reset_dut();
        set_w(0, 1); set_w(1, 1); gap = 2; enable = 1; req = 4'b0011;
        wait_done();
        check("t4_done0", 32'(done), 32'b0001);
        cnt = 0;
        for (int n = 0; n < 50 && !pulse_out; n++) begin
            @(negedge clk);
            if (busy && !pulse_out) cnt++;
        end
        check("t4_gap_cycles", 32'(cnt), 32'd2);
        check("t4_grant1", 32'(grant), 32'b0010);
        req = 0; gap = 0;

        // Enable dropped in the second pulse cycle.
        reset_dut();
        set_w(1, 5); gap = 0; enable = 1; req = 4'b0010;
        measure(2, len);
        check("t5_len", 32'(len), 32'd6);
        check("t5_done", 32'(done), 32'b0010);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (grant != '0) cnt++;
        end
        check("t5_no_grant", 32'(cnt), 32'd0);
        req = 0; enable = 1;

        // Async reset mid-pulse, then requester 3 wins from pointer 0.
        reset_dut();
        set_w(0, 7); set_w(3, 2); enable = 1; req = 4'b0001;
        wait_pulse_rise();
        #2 reset = 1'b1;
        #1;
        check("t6_async_pulse", 32'(pulse_out), 32'd0);
        check("t6_async_grant", 32'(grant), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        req = 4'b1000;
        @(posedge clk); #1 reset = 1'b0;
        wait_pulse_rise();
        check("t6_grant3", 32'(grant), 32'b1000);
        req = 0;

        // Randomized traffic against the schedule model.
        reset_dut();
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 3) == 0) req = NREQ'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) set_w($urandom_range(0, NREQ-1), $urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0)
                gap = ($urandom_range(0, 5) == 0) ? GAP_W'($urandom_range(0, 15)) : GAP_W'($urandom_range(0, 2));
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b1;
                @(posedge clk); #1 reset = 1'b0;
            end
        end
        req = 0;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
